// File: rtl/cmp_mon_pkg.sv
// Shared types and the per-bit four-valued equivalence rule for the mismatch monitor.
package cmp_mon_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    // An X on the impl side is a wildcard only in approx mode; Z never is.
    function automatic logic bit_ok(input logic spec_bit, input logic impl_bit, input logic approx);
        return (impl_bit === spec_bit) || (approx && (impl_bit === 1'bx));
    endfunction

endpackage

// File: rtl/cmp_mismatch_monitor_if.sv
// Bundle of compare inputs, verdict outputs and the report hand-off of one monitor instance.
interface cmp_mismatch_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             sample;
    logic             approx;
    logic             clear;
    logic [WIDTH-1:0] spec;
    logic [WIDTH-1:0] impl;
    logic             rpt_ready;

    logic             fail;
    logic [1:0]       state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] first_idx;
    logic [WIDTH-1:0] first_mask;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_idx;
    logic [WIDTH-1:0] rpt_mask;

    modport master (
        output sample, approx, clear, spec, impl, rpt_ready,
        input  fail, state, sample_cnt, err_cnt, drop_cnt,
               first_idx, first_mask, rpt_valid, rpt_idx, rpt_mask
    );

    modport slave (
        input  sample, approx, clear, spec, impl, rpt_ready,
        output fail, state, sample_cnt, err_cnt, drop_cnt,
               first_idx, first_mask, rpt_valid, rpt_idx, rpt_mask
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr is synchronous and wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign q = count_reg;
endmodule

// File: rtl/cmp_mismatch_monitor.sv
// Turns per-sample spec/impl equivalence into a sticky verdict, counters,
// first-failure capture and a one-entry report buffer for a downstream logger.
module cmp_mismatch_monitor
    import cmp_mon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic clk,
    input logic rst,
    cmp_mismatch_monitor_if.slave bus
);
    logic [WIDTH-1:0] mask;
    logic             take;
    logic             mismatch;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] drop_cnt;

    state_t           state_reg;
    logic [CNT_W-1:0] first_idx_reg;
    logic [WIDTH-1:0] first_mask_reg;
    logic             rpt_valid_reg;
    logic [CNT_W-1:0] rpt_idx_reg;
    logic [WIDTH-1:0] rpt_mask_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign mask[gi] = ~bit_ok(bus.spec[gi], bus.impl[gi], bus.approx);
    end

    // clear outranks sample, so a sample in a clearing cycle is ignored.
    assign take     = bus.sample & ~bus.clear;
    assign mismatch = take & (|mask);

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (take),
        .q   (sample_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (mismatch),
        .q   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (mismatch & rpt_valid_reg & ~bus.rpt_ready),
        .q   (drop_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            first_idx_reg  <= '0;
            first_mask_reg <= '0;
        end else if (bus.clear) begin
            state_reg      <= IDLE;
            first_idx_reg  <= '0;
            first_mask_reg <= '0;
        end else if (mismatch) begin
            if (state_reg != FAIL) begin
                first_idx_reg  <= sample_cnt;
                first_mask_reg <= mask;
            end
            state_reg <= FAIL;
        end else if (take && (state_reg == IDLE)) begin
            state_reg <= PASS;
        end
    end

    // A mismatch arriving while the logger takes the old entry replaces it in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_valid_reg <= 1'b0;
            rpt_idx_reg   <= '0;
            rpt_mask_reg  <= '0;
        end else if (bus.clear) begin
            rpt_valid_reg <= 1'b0;
            rpt_idx_reg   <= '0;
            rpt_mask_reg  <= '0;
        end else if (mismatch && (!rpt_valid_reg || bus.rpt_ready)) begin
            rpt_valid_reg <= 1'b1;
            rpt_idx_reg   <= sample_cnt;
            rpt_mask_reg  <= mask;
        end else if (bus.rpt_ready) begin
            rpt_valid_reg <= 1'b0;
        end
    end

    assign bus.fail       = (state_reg == FAIL);
    assign bus.state      = state_reg;
    assign bus.sample_cnt = sample_cnt;
    assign bus.err_cnt    = err_cnt;
    assign bus.drop_cnt   = drop_cnt;
    assign bus.first_idx  = first_idx_reg;
    assign bus.first_mask = first_mask_reg;
    assign bus.rpt_valid  = rpt_valid_reg;
    assign bus.rpt_idx    = rpt_idx_reg;
    assign bus.rpt_mask   = rpt_mask_reg;
endmodule

// File: tb/tb_cmp_mismatch_monitor.sv
// Self-checking bench: scenario tasks plus randomized traffic against a behavioural model.
module tb_cmp_mismatch_monitor;
    localparam int W    = 4;
    localparam int CW   = 16;
    localparam int CW2  = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmp_mismatch_monitor_if #(.WIDTH(W), .CNT_W(CW))  m1 ();
    cmp_mismatch_monitor_if #(.WIDTH(W), .CNT_W(CW2)) m2 ();

    cmp_mismatch_monitor #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m1)
    );

    cmp_mismatch_monitor #(.WIDTH(W), .CNT_W(CW2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (m2)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model of the 16-bit instance.
    int         m_state, m_samp, m_err, m_drop, m_fidx, m_ridx;
    logic [3:0] m_fmask, m_rmask;
    bit         m_rv;

    function automatic logic [3:0] model_mask(input logic [3:0] sp, input logic [3:0] im, input bit ap);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = !((im[i] === sp[i]) || (ap && (im[i] === 1'bx)));
        return r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_samp = 0; m_err = 0; m_drop = 0; m_fidx = 0; m_ridx = 0;
        m_fmask = '0; m_rmask = '0; m_rv = 0;
    endtask

    task automatic model_step(input bit s, input bit ap, input bit cl, input bit rdy,
                              input logic [3:0] sp, input logic [3:0] im);
        logic [3:0] mk;
        int         idx;
        bit         mis;
        if (cl) begin
            model_reset();
        end else begin
            mk  = model_mask(sp, im, ap);
            mis = s && (mk != 4'b0);
            idx = m_samp;
            if (s) m_samp = sat_inc(m_samp);
            if (mis) begin
                if (m_state != 2) begin
                    m_fidx  = idx;
                    m_fmask = mk;
                end
                m_state = 2;
                m_err   = sat_inc(m_err);
                if (!m_rv || rdy) begin
                    m_rv = 1; m_ridx = idx; m_rmask = mk;
                end else begin
                    m_drop = sat_inc(m_drop);
                end
            end else begin
                if (s && m_state == 0) m_state = 1;
                if (rdy) m_rv = 0;
            end
        end
    endtask

    function automatic logic [107:0] obs1();
        return {m1.fail, m1.state, m1.sample_cnt, m1.err_cnt, m1.drop_cnt,
                m1.first_idx, m1.first_mask, m1.rpt_valid, m1.rpt_idx, m1.rpt_mask};
    endfunction

    function automatic logic [107:0] exp1();
        return {(m_state == 2), 2'(m_state), 16'(m_samp), 16'(m_err), 16'(m_drop),
                16'(m_fidx), m_fmask, m_rv, 16'(m_ridx), m_rmask};
    endfunction

    task automatic step(input bit s, input bit ap, input bit cl, input bit rdy,
                        input logic [3:0] sp, input logic [3:0] im);
        m1.sample = s; m1.approx = ap; m1.clear = cl; m1.rpt_ready = rdy;
        m1.spec = sp; m1.impl = im;
        @(posedge clk);
        #1;
        model_step(s, ap, cl, rdy, sp, im);
        $display("[TB] txn s=%0b ap=%0b cl=%0b rdy=%0b spec=%b impl=%b -> st=%0d n=%0d err=%0d drop=%0d rv=%0b",
                 s, ap, cl, rdy, sp, im, m1.state, m1.sample_cnt, m1.err_cnt, m1.drop_cnt, m1.rpt_valid);
        m1.sample = 1'b0; m1.clear = 1'b0; m1.rpt_ready = 1'b0;
    endtask

    task automatic step2(input bit s, input bit cl, input logic [3:0] sp, input logic [3:0] im);
        m2.sample = s; m2.approx = 1'b0; m2.clear = cl; m2.rpt_ready = 1'b0;
        m2.spec = sp; m2.impl = im;
        @(posedge clk);
        #1;
        $display("[TB] txn sat s=%0b cl=%0b spec=%b impl=%b -> st=%0d n=%0d err=%0d drop=%0d",
                 s, cl, sp, im, m2.state, m2.sample_cnt, m2.err_cnt, m2.drop_cnt);
        m2.sample = 1'b0; m2.clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        model_reset();
        tests++;
        if (obs1() !== exp1()) begin
            fails++; $display("FAIL reset_main: got %h want %h", obs1(), exp1());
        end
        tests++;
        if ({m2.fail, m2.state, m2.sample_cnt, m2.rpt_valid} !== 7'b0) begin
            fails++; $display("FAIL reset_sat: got %b want 0", {m2.fail, m2.state, m2.sample_cnt, m2.rpt_valid});
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_pass_run();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 4'b1010, 4'b1010);
            tests++;
            if (obs1() !== exp1()) begin
                fails++; $display("FAIL pass_run[%0d]: got %h want %h", i, obs1(), exp1());
            end
        end
        tests++;
        if ({m1.state, m1.sample_cnt, m1.err_cnt, m1.fail, m1.rpt_valid} !== {2'd1, 16'd5, 16'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL pass_run_final: state=%0d n=%0d err=%0d fail=%0b rv=%0b required 1/5/0/0/0",
                              m1.state, m1.sample_cnt, m1.err_cnt, m1.fail, m1.rpt_valid);
        end
    endtask

    task automatic test_approx_x();
        logic [3:0] imp;
        imp = 4'b10x0;
        for (int mode = 1; mode >= 0; mode--) begin
            step(0, 0, 1, 0, 4'b0, 4'b0);
            for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'b1010, 4'b1010);
            step(1, bit'(mode), 0, 0, 4'b1010, imp);
            tests++;
            if (obs1() !== exp1()) begin
                fails++; $display("FAIL approx_x(mode=%0d): got %h want %h", mode, obs1(), exp1());
            end
            if ($isunknown(imp)) begin
                tests++;
                if (mode == 1 && {m1.fail, m1.err_cnt} !== 17'd0) begin
                    fails++; $display("FAIL approx_x_wild: fail=%0b err=%0d required 0/0", m1.fail, m1.err_cnt);
                end else if (mode == 0 && {m1.fail, m1.first_idx, m1.first_mask, m1.rpt_valid} !== {1'b1, 16'd3, 4'b0010, 1'b1}) begin
                    fails++; $display("FAIL approx_x_exact: fail=%0b idx=%0d mask=%b rv=%0b required 1/3/0010/1",
                                      m1.fail, m1.first_idx, m1.first_mask, m1.rpt_valid);
                end
            end
        end
    endtask

    task automatic test_z_not_wild();
        logic [3:0] imp;
        imp = 4'b1z10;
        step(0, 0, 1, 0, 4'b0, 4'b0);
        step(1, 1, 0, 0, 4'b1110, imp);
        tests++;
        if (obs1() !== exp1()) begin
            fails++; $display("FAIL z_wild: got %h want %h", obs1(), exp1());
        end
        if ($isunknown(imp)) begin
            tests++;
            if ({m1.fail, m1.first_mask} !== {1'b1, 4'b0100}) begin
                fails++; $display("FAIL z_wild_mask: fail=%0b mask=%b required 1/0100", m1.fail, m1.first_mask);
            end
        end
    endtask

    task automatic test_drop();
        step(0, 0, 1, 0, 4'b0, 4'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 4 || i == 6) step(1, 0, 0, 0, 4'b0000, 4'b0001);
            else                            step(1, 0, 0, 0, 4'b0110, 4'b0110);
            tests++;
            if (obs1() !== exp1()) begin
                fails++; $display("FAIL drop[%0d]: got %h want %h", i, obs1(), exp1());
            end
        end
        tests++;
        if ({m1.rpt_valid, m1.rpt_idx, m1.drop_cnt} !== {1'b1, 16'd2, 16'd2}) begin
            fails++; $display("FAIL drop_hold: rv=%0b idx=%0d drop=%0d required 1/2/2", m1.rpt_valid, m1.rpt_idx, m1.drop_cnt);
        end
        step(1, 0, 0, 1, 4'b0000, 4'b1000);
        tests++;
        if ({m1.rpt_valid, m1.rpt_idx, m1.rpt_mask, m1.drop_cnt} !== {1'b1, 16'd7, 4'b1000, 16'd2}) begin
            fails++; $display("FAIL drop_swap: rv=%0b idx=%0d mask=%b drop=%0d required 1/7/1000/2",
                              m1.rpt_valid, m1.rpt_idx, m1.rpt_mask, m1.drop_cnt);
        end
        step(0, 0, 0, 1, 4'b0000, 4'b1111);
        tests++;
        if (obs1() !== exp1() || m1.rpt_valid !== 1'b0) begin
            fails++; $display("FAIL drop_consume: got %h want %h", obs1(), exp1());
        end
    endtask

    task automatic test_random();
        logic [3:0] sp, im;
        step(0, 0, 1, 0, 4'b0, 4'b0);
        for (int i = 0; i < 300; i++) begin
            sp = 4'($urandom);
            im = ($urandom_range(0, 2) == 0) ? 4'($urandom) : sp;
            if ($urandom_range(0, 7) == 0) im[$urandom_range(0, 3)] = 1'bx;
            if ($urandom_range(0, 9) == 0) im[$urandom_range(0, 3)] = 1'bz;
            step($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
                 bit'($urandom_range(0, 1)), sp, im);
            tests++;
            if (obs1() !== exp1()) begin
                fails++; $display("FAIL random[%0d]: got %h want %h", i, obs1(), exp1());
            end
        end
    endtask

    task automatic test_saturation();
        step2(0, 1, 4'b0, 4'b0);
        for (int i = 0; i < 10; i++) begin
            step2(1, 0, 4'b0000, 4'b1111);
            if (i == 7) begin
                tests++;
                if (m2.sample_cnt !== 3'd7) begin
                    fails++; $display("FAIL sat_hold: n=%0d required 7", m2.sample_cnt);
                end
            end
        end
        tests++;
        if ({m2.sample_cnt, m2.err_cnt, m2.first_idx, m2.fail, m2.drop_cnt, m2.rpt_idx} !==
            {3'd7, 3'd7, 3'd0, 1'b1, 3'd7, 3'd0}) begin
            fails++; $display("FAIL sat_final: n=%0d err=%0d fidx=%0d fail=%0b drop=%0d ridx=%0d required 7/7/0/1/7/0",
                              m2.sample_cnt, m2.err_cnt, m2.first_idx, m2.fail, m2.drop_cnt, m2.rpt_idx);
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1, 0, 4'b0, 4'b0);
        step(1, 0, 0, 0, 4'b0101, 4'b0100);
        tests++;
        if ({m1.fail, m1.rpt_valid} !== 2'b11) begin
            fails++; $display("FAIL arst_setup: fail=%0b rv=%0b required 1/1", m1.fail, m1.rpt_valid);
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        tests++;
        if (obs1() !== exp1()) begin
            fails++; $display("FAIL arst_immediate: got %h want %h", obs1(), exp1());
        end
        @(posedge clk);
        #2 rst = 1'b0;
        step(1, 0, 0, 0, 4'b0011, 4'b0011);
        tests++;
        if (obs1() !== exp1() || m1.state !== 2'd1) begin
            fails++; $display("FAIL arst_recover: got %h want %h", obs1(), exp1());
        end
    endtask

    initial begin
        m1.sample = 0; m1.approx = 0; m1.clear = 0; m1.rpt_ready = 0; m1.spec = '0; m1.impl = '0;
        m2.sample = 0; m2.approx = 0; m2.clear = 0; m2.rpt_ready = 0; m2.spec = '0; m2.impl = '0;
        model_reset();
        test_reset();
        test_pass_run();
        test_approx_x();
        test_z_not_wild();
        test_drop();
        test_random();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cmp_mismatch_monitor.md
Name: cmp_mismatch_monitor

Overview:
- Consumes spec/impl output pairs produced by the flop-translation comparison bench and turns per-sample equivalence into a sticky verdict.
- Provides saturating counters, first-failure capture, and a one-entry failure report hand-off to a downstream logger.
- Simulation-only SystemVerilog. Comparisons are four-valued (case-equality semantics per bit).
- One instance per compared signal group, clocked by the bench's delayed clock.

Parameters:
- WIDTH, 4, bit width of the spec and impl vectors compared per sample.
- CNT_W, 16, width of the sample, error and drop counters; all saturate at 2**CNT_W-1.

Ports:
- clk  input  1  bench clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- sample  input  1  compare spec/impl this cycle.
- approx  input  1  1 = impl bit X is acceptable for any spec value; 0 = exact match required.
- clear  input  1  synchronous clear of counters, verdict and report buffer.
- spec  input  WIDTH  reference model outputs.
- impl  input  WIDTH  translated model outputs.
- rpt_ready  input  1  downstream logger accepts the report.
- fail  output  1  sticky; set on first mismatch.
- state  output  2  0 IDLE, 1 PASS, 2 FAIL.
- sample_cnt  output  CNT_W  samples taken.
- err_cnt  output  CNT_W  mismatching samples.
- drop_cnt  output  CNT_W  mismatches not reported because the buffer was full.
- first_idx  output  CNT_W  sample_cnt value at the first mismatch.
- first_mask  output  WIDTH  failing-bit mask of the first mismatch.
- rpt_valid  output  1  report buffer holds an entry.
- rpt_idx  output  CNT_W  sample index of the buffered mismatch.
- rpt_mask  output  WIDTH  failing-bit mask of the buffered mismatch.

Behaviour:
- Reset (async, rst=1): every output is 0 and state is IDLE. clear=1 on a clock edge gives the same result synchronously. clear has priority over sample in the same cycle.
- Per-bit ok[i]:
  - approx=0: (impl[i] === spec[i]).
  - approx=1: (impl[i] === spec[i]) | (impl[i] === 1'bx).
  - Z in impl is never a wildcard. X/Z in spec must be matched exactly.
- mask = ~ok. A sample mismatches iff mask != 0.
- All updates are registered; outputs reflect a sample on the cycle after it is taken (1-cycle latency).
- On sample=1:
  - sample_cnt increments (saturating).
  - The index recorded for this sample is the pre-increment sample_cnt.
- FSM:
  - IDLE -> PASS on the first sample without a mismatch.
  - IDLE or PASS -> FAIL on any mismatching sample.
  - FAIL holds until rst or clear.
  - fail = (state==FAIL).
- On the first mismatch (IDLE/PASS -> FAIL transition): capture first_idx and first_mask. Both are held thereafter.
- On every mismatch: err_cnt increments (saturating).
- Report buffer (one entry):
  - Mismatch with rpt_valid=0: load rpt_idx/rpt_mask and set rpt_valid.
  - Mismatch with rpt_valid=1 and rpt_ready=0: drop_cnt increments (saturating); buffer is unchanged.
  - Mismatch with rpt_valid=1 and rpt_ready=1 in the same cycle: the old entry is consumed and the new one loads; rpt_valid stays 1; no drop.
  - rpt_ready with no new mismatch: rpt_valid clears.
  - rpt_idx/rpt_mask are stable while rpt_valid=1 and rpt_ready=0.
- sample=0: no state changes except report consumption via rpt_ready.
- Saturation: once a counter reaches all-ones it holds. The FSM and report buffer still operate normally.
- rst asserted mid-report discards the pending entry without a handshake.

Decomposition:
- Shared package cmp_mon_pkg:
  - enum state_t {IDLE, PASS, FAIL}.
  - Function bit_ok(spec_bit, impl_bit, approx).
  - Localparam default CNT_W.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is natural. It is used three times.

Test Plan:
- Reset, then 5 samples with spec=impl=4'b1010, approx=0 -> state=PASS, sample_cnt=5, err_cnt=0, fail=0, rpt_valid=0.
- Sample 3 has spec=4'b1010, impl=4'b10x0, approx=1 -> no error. The same sample with approx=0 -> fail=1, first_idx=3, first_mask=4'b0010, rpt_valid=1.
- impl=4'b1z10 vs spec=4'b1110, approx=1 -> mismatch with mask=4'b0100 (Z is not a wildcard).
- rpt_ready held 0 and three mismatches at indices 2, 4, 6:
  - rpt_idx=2, drop_cnt=2.
  - Then rpt_ready=1 concurrent with a mismatch at 7 -> rpt_idx=7, rpt_valid=1, drop_cnt unchanged.
- CNT_W=3, 10 mismatching samples -> sample_cnt=7, err_cnt=7, first_idx=0, fail=1.
- Assert rst asynchronously between edges while state=FAIL and rpt_valid=1 -> all outputs 0 immediately. A clean sample afterwards -> state=PASS.
